// File: rtl/operand_entry.sv
// Operand entry stage: synchronises and debounces three active-low buttons,
// steps two W-bit operands on A/B presses, clears both on CLR, drives them active-low.
module operand_entry #(
   parameter int W              = 2,
   parameter int DEBOUNCE_LIMIT = 500000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_a_n,
   input  logic         key_b_n,
   input  logic         key_clr_n,
   output logic [W-1:0] out_a_n,
   output logic [W-1:0] out_b_n,
   output logic         press_a,
   output logic         press_b,
   output logic         press_clr
);

   localparam int NK = 3;
   localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

   // Key index: 0 = A, 1 = B, 2 = CLR.
   logic [NK-1:0] raw_n;
   assign raw_n = {key_clr_n, key_b_n, key_a_n};

   logic [NK-1:0] sync1_q, sync1_d;
   logic [NK-1:0] sync2_q, sync2_d;
   logic [NK-1:0] stable_q, stable_d;
   logic [NK-1:0] press_q, press_d;
   logic [CW-1:0] cnt_q [NK];
   logic [CW-1:0] cnt_d [NK];
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;

   always_comb begin
      sync1_d  = raw_n;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      press_d  = '0;
      cnt_d    = cnt_q;
      // The counter only advances while the synchronised level disagrees with stable.
      for (int k = 0; k < NK; k++) begin
         if (sync2_q[k] == stable_q[k]) begin
            cnt_d[k] = '0;
         end else if (cnt_q[k] == CNT_LAST) begin
            stable_d[k] = sync2_q[k];
            cnt_d[k]    = '0;
            press_d[k]  = stable_q[k] & ~sync2_q[k];
         end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
         end
      end

      a_d = a_q;
      b_d = b_q;
      // Clear beats any same-cycle increment.
      if (press_d[2]) begin
         a_d = '0;
         b_d = '0;
      end else begin
         if (press_d[0]) a_d = a_q + W'(1);
         if (press_d[1]) b_d = b_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '1;
         sync2_q  <= '1;
         stable_q <= '1;
         press_q  <= '0;
         cnt_q    <= '{default: '0};
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
      end
   end

   assign out_a_n   = ~a_q;
   assign out_b_n   = ~b_q;
   assign press_a   = press_q[0];
   assign press_b   = press_q[1];
   assign press_clr = press_q[2];

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: window-based reference model of sync/debounce/operands,
// scenario tasks with targeted constant checks plus a randomized run.
module tb_operand_entry;
   localparam int W = 2;
   localparam int LIM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key_a_n = 1'b1, key_b_n = 1'b1, key_clr_n = 1'b1;
   logic [W-1:0] out_a_n, out_b_n;
   logic press_a, press_b, press_clr;

   operand_entry #(.W(W), .DEBOUNCE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .key_a_n(key_a_n), .key_b_n(key_b_n), .key_clr_n(key_clr_n),
      .out_a_n(out_a_n), .out_b_n(out_b_n),
      .press_a(press_a), .press_b(press_b), .press_clr(press_clr)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: 2-deep sync pipe, then a key's level is accepted once the
   // last LIM synchronised samples all differ from the accepted level.
   bit m_s1 [3];
   bit m_s2 [3];
   bit m_st [3];
   bit m_hist [3][$];
   bit [2:0] m_press;
   int m_a, m_b;

   int cnt_pa, cnt_pb, cnt_pc, first_pa, tick_idx;
   bit both_same;

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_st[k] = 1'b1;
         m_hist[k].delete();
      end
      m_press = '0; m_a = 0; m_b = 0;
   endtask

   task automatic model_edge(input logic [2:0] raw);
      bit all_diff;
      if (rst) begin
         model_reset();
         return;
      end
      m_press = '0;
      for (int k = 0; k < 3; k++) begin
         m_hist[k].push_back(m_s2[k]);
         if (m_hist[k].size() > LIM) void'(m_hist[k].pop_front());
         if (m_hist[k].size() == LIM) begin
            all_diff = 1'b1;
            foreach (m_hist[k][i]) if (m_hist[k][i] == m_st[k]) all_diff = 1'b0;
            if (all_diff) begin
               m_st[k] = ~m_st[k];
               m_hist[k].delete();
               m_press[k] = (m_st[k] == 1'b0);
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         m_s2[k] = m_s1[k];
         m_s1[k] = raw[k];
      end
      if (m_press[2]) begin
         m_a = 0; m_b = 0;
      end else begin
         if (m_press[0]) m_a = (m_a + 1) % (1 << W);
         if (m_press[1]) m_b = (m_b + 1) % (1 << W);
      end
   endtask

   function automatic logic [6:0] exp_vec();
      logic [W-1:0] ea, eb;
      ea = ~W'(m_a);
      eb = ~W'(m_b);
      return {ea, eb, m_press[0], m_press[1], m_press[2]};
   endfunction

   task automatic clear_counts();
      cnt_pa = 0; cnt_pb = 0; cnt_pc = 0; first_pa = -1; tick_idx = 0; both_same = 1'b0;
   endtask

   // Driver: keys bit0=A, bit1=B, bit2=CLR (0 = pressed); one clock per iteration.
   task automatic hold(input logic [2:0] keys, input int n);
      logic [6:0] obs;
      for (int i = 0; i < n; i++) begin
         key_a_n = keys[0]; key_b_n = keys[1]; key_clr_n = keys[2];
         @(posedge clk);
         model_edge(keys);
         #1;
         obs = {out_a_n, out_b_n, press_a, press_b, press_clr};
         n_vec++;
         if (obs !== exp_vec()) begin
            n_err++;
            $display("FAIL model t=%0t got %b want %b", $time, obs, exp_vec());
         end
         if (press_a === 1'b1) begin
            cnt_pa++;
            if (first_pa < 0) first_pa = tick_idx;
         end
         if (press_b === 1'b1) cnt_pb++;
         if (press_clr === 1'b1) cnt_pc++;
         if (press_a === 1'b1 && press_clr === 1'b1) both_same = 1'b1;
         tick_idx++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      hold(3'b111, 2);
      rst = 1'b0;
      hold(3'b111, 2);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         hold(3'($urandom_range(0, 7)), 1);
         n_vec++;
         if ({out_a_n, out_b_n, press_a, press_b, press_clr} !== 7'b1111000) begin
            n_err++;
            $display("FAIL reset_hold got %b want 1111000", {out_a_n, out_b_n, press_a, press_b, press_clr});
         end
      end
      rst = 1'b0;
      hold(3'b111, 6);
   endtask

   task automatic test_hold_a();
      do_reset();
      clear_counts();
      hold(3'b110, 20);
      n_vec++;
      if (cnt_pa != 1 || first_pa != 5) begin
         n_err++;
         $display("FAIL hold_a_timing got cnt=%0d idx=%0d want cnt=1 idx=5", cnt_pa, first_pa);
      end
      hold(3'b111, 10);
      n_vec++;
      if (out_a_n !== 2'b10 || out_b_n !== 2'b11 || cnt_pa != 1) begin
         n_err++;
         $display("FAIL hold_a_value got a=%b b=%b cnt=%0d want a=10 b=11 cnt=1", out_a_n, out_b_n, cnt_pa);
      end
   endtask

   task automatic test_four_presses();
      logic [W-1:0] tbl [4];
      tbl[0] = 2'b10; tbl[1] = 2'b01; tbl[2] = 2'b00; tbl[3] = 2'b11;
      do_reset();
      clear_counts();
      for (int j = 0; j < 4; j++) begin
         hold(3'b110, 8);
         hold(3'b111, 8);
         n_vec++;
         if (out_a_n !== tbl[j]) begin
            n_err++;
            $display("FAIL four_presses step %0d got %b want %b", j, out_a_n, tbl[j]);
         end
      end
      n_vec++;
      if (cnt_pa != 4) begin
         n_err++;
         $display("FAIL four_presses_count got %0d want 4", cnt_pa);
      end
   endtask

   task automatic test_bounce_b();
      do_reset();
      clear_counts();
      for (int j = 0; j < 5; j++) begin
         hold(3'b101, 3);
         hold(3'b111, 1);
      end
      hold(3'b111, 8);
      n_vec++;
      if (cnt_pb != 0 || out_b_n !== 2'b11) begin
         n_err++;
         $display("FAIL bounce_b got cnt=%0d b=%b want cnt=0 b=11", cnt_pb, out_b_n);
      end
      hold(3'b101, 10);
      n_vec++;
      if (cnt_pb != 1 || out_b_n !== 2'b10) begin
         n_err++;
         $display("FAIL bounce_b_press got cnt=%0d b=%b want cnt=1 b=10", cnt_pb, out_b_n);
      end
      hold(3'b111, 8);
   endtask

   task automatic test_clr_wins();
      do_reset();
      for (int j = 0; j < 2; j++) begin
         hold(3'b100, 8);
         hold(3'b111, 8);
      end
      hold(3'b101, 8);
      hold(3'b111, 8);
      n_vec++;
      if (out_a_n !== 2'b01 || out_b_n !== 2'b00) begin
         n_err++;
         $display("FAIL clr_setup got a=%b b=%b want a=01 b=00", out_a_n, out_b_n);
      end
      clear_counts();
      hold(3'b010, 8);
      n_vec++;
      if (!both_same || cnt_pa != 1 || cnt_pc != 1 || out_a_n !== 2'b11 || out_b_n !== 2'b11) begin
         n_err++;
         $display("FAIL clr_wins got same=%0d pa=%0d pc=%0d a=%b b=%b want 1 1 1 11 11",
                  both_same, cnt_pa, cnt_pc, out_a_n, out_b_n);
      end
      hold(3'b111, 8);
   endtask

   task automatic test_rst_mid_debounce();
      do_reset();
      hold(3'b110, 4);
      rst = 1'b1;
      hold(3'b110, 2);
      rst = 1'b0;
      clear_counts();
      hold(3'b110, 12);
      n_vec++;
      if (cnt_pa != 1 || first_pa != 5 || out_a_n !== 2'b10) begin
         n_err++;
         $display("FAIL rst_mid got cnt=%0d idx=%0d a=%b want cnt=1 idx=5 a=10", cnt_pa, first_pa, out_a_n);
      end
      hold(3'b111, 8);
   endtask

   task automatic test_random();
      do_reset();
      for (int j = 0; j < 300; j++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            hold(3'($urandom_range(0, 7)), 1);
            rst = 1'b0;
         end
         hold(3'($urandom_range(0, 7)), $urandom_range(1, 9));
      end
   endtask

   initial begin
      model_reset();
      clear_counts();
      test_reset();
      test_hold_a();
      test_four_presses();
      test_bounce_b();
      test_clr_wins();
      test_rst_mid_debounce();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Upstream input stage for the signed/unsigned adder demo on the EPM240 board.
- Synchronises and debounces three active-low push-buttons. Each press of the A or B button steps a 2-bit operand; the clear button zeroes both.
- Drives the operands out in active-low form, so they connect straight to the adder's active-low in_a/in_b inputs.
- Replaces raw DIP/button wiring with repeatable, glitch-free operand stepping.

Parameters:
- W, 2, operand width in bits. Operands wrap modulo 2^W.
- DEBOUNCE_LIMIT, 500000, consecutive stable cycles needed to accept a key change (10 ms at 50 MHz). Legal range is ≥1; the bench uses 4.

Ports:
- clk  input  1  system clock, 50 MHz on board
- rst  input  1  asynchronous, active-high reset
- key_a_n  input  1  raw button A, active-low, asynchronous to clk
- key_b_n  input  1  raw button B, active-low, asynchronous to clk
- key_clr_n  input  1  raw clear button, active-low, asynchronous to clk
- out_a_n  output  W  operand A, active-low (bitwise inverse of the internal value)
- out_b_n  output  W  operand B, active-low
- press_a  output  1  one-cycle pulse when A is accepted
- press_b  output  1  one-cycle pulse when B is accepted
- press_clr  output  1  one-cycle pulse when clear is accepted

Behaviour:
- Reset (asynchronous, active-high):
  - Per key: sync flops = 1, stable state = 1 (released), debounce counter = 0.
  - Internal operands = 0, so out_a_n = out_b_n = all ones.
  - press_* = 0.
  - Asserting rst mid-debounce or mid-pulse aborts it immediately.
  - A key still held at reset release is seen as pressed only after a full debounce. It then generates one press, because stable starts at "released".
- Synchroniser: 2-flop chain per key. Nothing downstream uses the raw inputs.
- Debounce, identical logic per key:
  - counter width is clog2(DEBOUNCE_LIMIT+1).
  - If sync_out == stable: counter <= 0.
  - Else if counter == DEBOUNCE_LIMIT-1: stable <= sync_out and counter <= 0.
  - Else: counter <= counter+1.
  - A bounce shorter than DEBOUNCE_LIMIT cycles restarts the count and produces no event.
- Press event:
  - Fires on the clock edge where stable goes from 1 to 0.
  - The matching press_* is registered high for exactly that one cycle.
  - Release (0→1) is debounced the same way but produces no event.
  - Holding a key produces no auto-repeat.
- Latency: if the raw key first reads low at edge t and then stays low, stable changes at edge t+1+DEBOUNCE_LIMIT. press_* and the operand update are visible in the cycle after that edge.
- Operand update is registered on the same edge as its press pulse:
  - press_a → A <= A+1 mod 2^W, so 3 wraps to 0. B is handled the same way.
  - press_clr → A <= 0 and B <= 0.
- Simultaneous events:
  - Clear wins over any increment in the same cycle. press_a/press_b still pulse.
  - A and B in the same cycle both increment independently.
- Outputs:
  - out_a_n = ~A and out_b_n = ~B, driven directly from registers.
  - No combinational path from any input to any output.

Test Plan (DEBOUNCE_LIMIT=4, W=2):
- Reset → out_a_n=2'b11, out_b_n=2'b11, all press_*=0. Hold rst while toggling keys: outputs stay unchanged.
- Hold key_a_n=0 for 20 cycles, then release → exactly one press_a pulse, 1+4 cycles after the first sampled low. out_a_n goes from 11 to 10 (A=1). out_b_n is unchanged.
- Press A cleanly four times → A steps 1,2,3,0, giving out_a_n = 10,01,00,11. Four press_a pulses.
- Bounce key_b_n low for 3 cycles, high for 1, repeated five times, then hold high → no press_b, and B stays 0. Then hold low for 10 cycles → one press_b, B=1.
- With A=2 and B=3, make clr and A reach their accept edge in the same cycle → press_clr and press_a both pulse, and A=0, B=0 (out_*_n=11).
- Assert rst at debounce counter=2 while key_a_n is held low, release rst with the key still low → no pulse before a fresh 1+4 cycles. Exactly one press_a follows, then A=1.
